// File: rtl/upc_rotator.sv
// Capture-and-rotate controller for the UPC seven-segment display: buffers up to DEPTH cat
// codes on load edges, then cycles through them, showing each for DWELL clock cycles.
module upc_rotator #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [2:0]               upc_in,
    input  logic                     load,
    input  logic                     clear,
    output logic [2:0]               upc_out,
    output logic                     show,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     full,
    output logic                     err
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned DW = $clog2(DWELL);

    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          load_q;
    logic          armed_q, armed_d;
    logic          err_q, err_d;
    logic [2:0]    mem_q [DEPTH];

    logic req;
    logic code_ok;
    logic is_full;
    logic accept;
    logic reject;

    assign is_full = (count_q == CountFull);
    assign code_ok = (upc_in != 3'b010) && (upc_in != 3'b111);
    // armed_q blocks a load already held high across reset release from counting as an edge.
    assign req     = load && !load_q && armed_q;
    assign accept  = req && code_ok && !is_full && !clear;
    assign reject  = req && (!code_ok || is_full) && !clear;
    assign armed_d = armed_q || !load;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        err_d   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            idx_d   = '0;
            dwell_d = '0;
        end else begin
            err_d = reject;
            // Wrap decision uses the pre-edge count; a same-edge accept joins on the next pass.
            if (state_q == ST_SHOW) begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (CW'(idx_q) == count_q - CW'(1)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            if (accept) begin
                count_d = count_q + CW'(1);
                if (state_q == ST_IDLE) begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    dwell_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
            load_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            load_q  <= load;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'b000;
            end
        end else if (accept) begin
            mem_q[count_q[IW-1:0]] <= upc_in;
        end
    end

    assign show    = (state_q == ST_SHOW);
    assign upc_out = show ? mem_q[idx_q] : 3'b000;
    assign count   = count_q;
    assign idx     = idx_q;
    assign full    = is_full;
    assign err     = err_q;

endmodule

// File: tb/tb_upc_rotator.sv
// Randomised scoreboard bench for upc_rotator: a queue-based reference model predicts the outputs
// after every clock edge and a negedge monitor compares them against the DUT.
module tb_upc_rotator;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] upc_in = 3'b000;
    logic       load = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] upc_out;
    logic       show;
    logic [2:0] count;
    logic [1:0] idx;
    logic       full;
    logic       err;

    upc_rotator #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .upc_in  (upc_in),
        .load    (load),
        .clear   (clear),
        .upc_out (upc_out),
        .show    (show),
        .count   (count),
        .idx     (idx),
        .full    (full),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int upc;
        int show;
        int count;
        int idx;
        int full;
        int err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: the stored codes as a plain list, plus display position and elapsed cycles.
    int m_mem[$];
    bit m_show;
    int m_pos;
    int m_cyc;
    bit m_prev;
    bit m_err;

    function automatic void model_reset();
        m_mem.delete();
        m_show = 0;
        m_pos  = 0;
        m_cyc  = 0;
        m_err  = 0;
        m_prev = 1; // a load high at release must first be seen low
    endfunction

    function automatic void model_edge(bit ld, bit cl, int code);
        bit req;
        bit ok;
        int n;
        req    = ld && !m_prev;
        m_prev = ld;
        if (cl) begin
            m_mem.delete();
            m_show = 0;
            m_pos  = 0;
            m_cyc  = 0;
            m_err  = 0;
            return;
        end
        n = m_mem.size();
        if (m_show) begin
            m_cyc++;
            if (m_cyc == DWELL) begin
                m_cyc = 0;
                m_pos = (m_pos + 1) % n;
            end
        end
        ok    = (code != 2) && (code != 7);
        m_err = req && !(ok && n < DEPTH);
        if (req && ok && n < DEPTH) begin
            m_mem.push_back(code);
            if (!m_show) begin
                m_show = 1;
                m_pos  = 0;
                m_cyc  = 0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.upc   = m_show ? m_mem[m_pos] : 0;
        e.show  = int'(m_show);
        e.count = m_mem.size();
        e.idx   = m_pos;
        e.full  = int'(m_mem.size() == DEPTH);
        e.err   = int'(m_err);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".upc_out"}, int'(upc_out), e.upc);
        check({tag, ".show"}, int'(show), e.show);
        check({tag, ".count"}, int'(count), e.count);
        check({tag, ".idx"}, int'(idx), e.idx);
        check({tag, ".full"}, int'(full), e.full);
        check({tag, ".err"}, int'(err), e.err);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_all("cycle", e);
        end
    end

    task automatic step(input bit ld, input bit cl, input int code);
        load   = ld;
        clear  = cl;
        upc_in = 3'(code);
        @(posedge clk);
        model_edge(ld, cl, code);
        sb.push_back(model_out());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, int'($urandom_range(0, 7)));
    endtask

    task automatic push_code(input int code);
        step(1, 0, code);
        step(0, 0, code);
    endtask

    task automatic do_reset(input bit hold_load);
        exp_t e;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        e = model_out();
        check_all("async_reset", e);
        load  = hold_load;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(3);

        // Single entry: same code forever, idx pinned at 0.
        push_code(3);
        idle(20);

        // Rotation over three entries.
        step(0, 1, 0);
        push_code(0);
        push_code(1);
        push_code(5);
        idle(30);

        // Fill, then reject an overflow; then reject an invalid code while not full.
        step(0, 1, 0);
        push_code(0);
        push_code(1);
        push_code(3);
        push_code(4);
        push_code(6);
        idle(3);
        step(0, 1, 0);
        push_code(7);
        push_code(2);
        idle(3);

        // Accept on the same edge as the idx=1 -> 0 wrap.
        step(0, 1, 0);
        push_code(1);
        push_code(4);
        guard = 0;
        while (!(m_pos == 1 && m_cyc == DWELL - 1) && guard < 40) begin
            step(0, 0, 0);
            guard++;
        end
        check("wrap_align_timeout", int'(guard < 40), 1);
        step(1, 0, 6);
        idle(30);

        // Clear coincident with a load edge.
        step(0, 0, 0);
        step(1, 1, 3);
        step(1, 0, 3);
        step(0, 0, 3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 7)));
        end

        // Reset mid-rotation with load held high across release.
        step(0, 1, 0);
        push_code(5);
        push_code(3);
        idle(6);
        do_reset(1'b1);
        step(1, 0, 4);
        step(1, 0, 4);
        step(0, 0, 4);
        step(1, 0, 4);
        idle(10);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upc_rotator.md
# upc_rotator

Sequencing controller for the UPC seven-segment display datapath. Captures up to DEPTH cat UPC codes entered on the switches, one per press of a load input. It then rotates through the stored codes, presenting each on `upc_out` for DWELL clock cycles. `upc_out` drives the existing 3-bit UPC-to-HEX3..HEX0 decoder; `show` tells the top level when to blank the digits.

## Interface
- DEPTH, 4: number of UPC entries stored; power of two, 2..8.
- DWELL, 50_000_000: clock cycles each entry is displayed; at least 2.
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- upc_in  input  3  UPC code from switches SW[2:0].
- load  input  1  level input, already debounced and synchronized; a rising edge requests capture of upc_in.
- clear  input  1  synchronous; empties the buffer while high.
- upc_out  output  3  code to the display decoder.
- show  output  1  1 = upc_out is a stored entry; 0 = the top level blanks HEX3..HEX0.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- idx  output  $clog2(DEPTH)  index of the entry currently displayed.
- full  output  1  count == DEPTH.
- err  output  1  one-cycle pulse when a load request is rejected.

## Operation
- Valid cat codes are 000, 001, 011, 100, 101 and 110. Codes 010 and 111 are invalid.
- Load edge detect: a registered copy load_q is kept. A load request is the condition load==1 && load_q==0 at a clock edge.
- Accept: request && valid code && !full && !clear. On accept, mem[count] <= upc_in and count increments.
- Reject: request && (invalid code || full) && !clear. On reject, err=1 for exactly one cycle; mem and count are unchanged.
- clear has priority over load. While clear is high:
  - count is 0, the state is IDLE, and idx and dwell_cnt are 0.
  - mem contents are don't-care.
  - A load edge coinciding with clear is discarded with no err pulse.
- FSM states:
  - IDLE: count==0; show=0; upc_out=000.
  - SHOW: show=1; upc_out=mem[idx].
- IDLE -> SHOW on the first accepted load. idx and dwell_cnt are 0 on entry.
- SHOW -> IDLE only on clear or reset.
- dwell_cnt counts 0..DWELL-1 in SHOW. At the edge where dwell_cnt==DWELL-1:
  - dwell_cnt returns to 0.
  - idx <= (idx==count-1) ? 0 : idx+1. count here is its pre-edge value.
- An accept on the same edge as a wrap does not affect that wrap decision. The new entry is reached on the next pass.
- With count==1, idx stays 0 and the same code is redisplayed indefinitely.
- upc_out, show, full and idx are combinational from registered state only. No path runs from upc_in or load to any output.

## Timing
- Reset values: upc_out=000, show=0, count=0, idx=0, full=0, err=0. Also state=IDLE, dwell_cnt=0, load_q=0.
- Reset mid-operation forces all of the above immediately, without waiting for a clock edge.
- After reset release, a load already held high is not a request. It must go low and then high again.
- Capture latency: the new entry is visible on count/full/upc_out in the cycle after the accepting edge. From IDLE, show rises in that same cycle.
- Each entry is displayed for exactly DWELL cycles. The full rotation period is count*DWELL cycles.
- err asserts in the cycle after the rejecting edge and lasts exactly one cycle.

## Test plan
Bench parameters: DEPTH=4, DWELL=4.
- Reset: assert reset_n=0 mid-rotation -> all outputs return to their reset values immediately; load held high through release -> no capture.
- Single entry: load 011 -> show=1, upc_out=011, count=1; after 20 cycles upc_out is still 011 and idx is still 0.
- Rotation: load 000, 001, 101 -> upc_out sequence is 000 x4, 001 x4, 101 x4, then back to 000; idx goes 0,1,2,0.
- Full/reject: load 000, 001, 011, 100 -> full=1; fifth load 110 -> err pulse of 1 cycle, count stays 4. Load 111 while not full -> err, no capture.
- Wrap collision: with count=2, accept 110 on the edge where idx=1 and dwell_cnt=3 -> idx goes to 0, count=3, and 110 is displayed after entry 1 on the next pass.
- Clear: assert clear together with a load edge -> count=0, show=0, upc_out=000, no err.
